// File: rtl/race_pkg.sv
// Shared types and constants for the race sequencer.
// The optional BEST_LAP_EN build is selected inside race_sequencer.sv.
package race_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        RACING    = 3'd2,
        PAUSED    = 3'd3,
        PENALTY   = 3'd4,
        FINISHED  = 3'd5
    } race_state_e;

    localparam logic [9:0] BEST_NONE = 10'h3FF;
    localparam logic [1:0] DIGIT_GO  = 2'd0;

    function automatic logic [3:0] lap_sat_inc(input logic [3:0] n);
        return (n == 4'hF) ? n : n + 4'd1;
    endfunction

endpackage

// File: rtl/race_sequencer_if.sv
// Player/track inputs and timer/HUD outputs of the race sequencer.
// master drives the inputs and observes the outputs; slave is the sequencer.
interface race_sequencer_if;

    logic       refresh_tick;
    logic       start_btn;
    logic       pause_btn;
    logic       crash;
    logic       lap_cross;
    logic [9:0] race_time;
    logic       timer_reset;
    logic       timer_pause;
    logic       countdown_on;
    logic [1:0] countdown_digit;
    logic [3:0] lap_count;
    logic [9:0] best_lap;
    logic       race_done;
    logic       timed_out;
    logic [2:0] state;

    modport master (
        output refresh_tick, start_btn, pause_btn, crash, lap_cross, race_time,
        input  timer_reset, timer_pause, countdown_on, countdown_digit, lap_count,
               best_lap, race_done, timed_out, state
    );

    modport slave (
        input  refresh_tick, start_btn, pause_btn, crash, lap_cross, race_time,
        output timer_reset, timer_pause, countdown_on, countdown_digit, lap_count,
               best_lap, race_done, timed_out, state
    );

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector: rise is high for the one cycle where din is high
// and the registered previous sample is low.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= din;
    end

    assign rise = din & ~prev_q;

endmodule

// File: rtl/race_sequencer.sv
// Race-flow FSM: 3-2-1-GO countdown, run, pause, crash penalty, finish, lap counting.
// Define BEST_LAP_EN to build best-lap tracking; otherwise best_lap is tied to BEST_NONE.
module race_sequencer
    import race_pkg::*;
#(
    parameter int unsigned NUM_LAPS    = 3,
    parameter int unsigned STEP_FRAMES = 60,
    parameter int unsigned PEN_FRAMES  = 90,
    parameter int unsigned MAX_TIME    = 999
) (
    input logic             clk,
    input logic             reset,
    race_sequencer_if.slave bus
);

    localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);
    localparam logic [7:0] PEN_LAST  = 8'(PEN_FRAMES - 1);
    localparam logic [3:0] LAPS_END  = 4'(NUM_LAPS);
    localparam logic [9:0] TIME_END  = 10'(MAX_TIME);

    race_state_e state_q, state_d;
    logic [7:0]  frame_q, frame_d;
    logic [1:0]  digit_q, digit_d;
    logic [3:0]  lap_q, lap_d;
    logic        cd_on_q, cd_on_d;
    logic        timed_out_q, timed_out_d;
    logic        timer_reset_q, timer_pause_q, race_done_q;
    logic        start_rise, pause_rise, crash_rise;
    logic        lap_event, time_up;
    logic [3:0]  lap_inc;

    rise_detect u_start (.clk(clk), .reset(reset), .din(bus.start_btn), .rise(start_rise));
    rise_detect u_pause (.clk(clk), .reset(reset), .din(bus.pause_btn), .rise(pause_rise));
    rise_detect u_crash (.clk(clk), .reset(reset), .din(bus.crash),     .rise(crash_rise));

    assign time_up = (bus.race_time >= TIME_END);
    assign lap_inc = lap_sat_inc(lap_q);

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        digit_d     = digit_q;
        cd_on_d     = cd_on_q;
        lap_d       = lap_q;
        timed_out_d = timed_out_q;
        lap_event   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = COUNTDOWN;
                    digit_d = 2'd3;
                end
            end
            COUNTDOWN: begin
                if (bus.refresh_tick) begin
                    if (frame_q == STEP_LAST) begin
                        frame_d = '0;
                        digit_d = digit_q - 2'd1;
                        if (digit_d == DIGIT_GO) state_d = RACING;
                    end else begin
                        frame_d = frame_q + 8'd1;
                    end
                end
            end
            RACING: begin
                // Frame counter times the "GO" step until countdown_on drops.
                if (cd_on_q && bus.refresh_tick) begin
                    if (frame_q == STEP_LAST) begin
                        frame_d = '0;
                        cd_on_d = 1'b0;
                    end else begin
                        frame_d = frame_q + 8'd1;
                    end
                end
                if (time_up) begin
                    state_d     = FINISHED;
                    timed_out_d = 1'b1;
                end else if (bus.lap_cross) begin
                    lap_event = 1'b1;
                    if (lap_inc == LAPS_END) state_d = FINISHED;
                end else if (crash_rise) begin
                    state_d = PENALTY;
                end else if (pause_rise) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (pause_rise) state_d = RACING;
            end
            PENALTY: begin
                // The timer keeps running here, so a timeout or final lap still ends the race.
                if (time_up) begin
                    state_d     = FINISHED;
                    timed_out_d = 1'b1;
                end else begin
                    if (bus.lap_cross) begin
                        lap_event = 1'b1;
                        if (lap_inc == LAPS_END) state_d = FINISHED;
                    end
                    if (state_d == PENALTY && bus.refresh_tick) begin
                        if (frame_q == PEN_LAST) state_d = RACING;
                        else                     frame_d = frame_q + 8'd1;
                    end
                end
            end
            FINISHED: begin
                if (start_rise) begin
                    state_d     = COUNTDOWN;
                    digit_d     = 2'd3;
                    lap_d       = '0;
                    timed_out_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (lap_event) lap_d = lap_inc;

        // COUNTDOWN -> RACING keeps countdown_on for the "GO" step; other transitions set it.
        if (state_d != state_q) begin
            frame_d = '0;
            if (state_q != COUNTDOWN) cd_on_d = (state_d == COUNTDOWN);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            frame_q       <= '0;
            digit_q       <= 2'd3;
            lap_q         <= '0;
            cd_on_q       <= 1'b0;
            timed_out_q   <= 1'b0;
            timer_reset_q <= 1'b1;
            timer_pause_q <= 1'b1;
            race_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            digit_q       <= digit_d;
            lap_q         <= lap_d;
            cd_on_q       <= cd_on_d;
            timed_out_q   <= timed_out_d;
            timer_reset_q <= (state_d == IDLE) || (state_d == COUNTDOWN);
            timer_pause_q <= (state_d == IDLE) || (state_d == COUNTDOWN) ||
                             (state_d == PAUSED) || (state_d == FINISHED);
            race_done_q   <= (state_d == FINISHED);
        end
    end

`ifdef BEST_LAP_EN
    logic [9:0] best_q, lap_start_q, lap_time;

    assign lap_time = bus.race_time - lap_start_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_q      <= BEST_NONE;
            lap_start_q <= '0;
        end else if (state_q == FINISHED && start_rise) begin
            best_q      <= BEST_NONE;
            lap_start_q <= '0;
        end else if (lap_event) begin
            lap_start_q <= bus.race_time;
            if (lap_time < best_q) best_q <= lap_time;
        end
    end

    assign bus.best_lap = best_q;
`else
    assign bus.best_lap = BEST_NONE;
`endif

    assign bus.state           = state_q;
    assign bus.timer_reset     = timer_reset_q;
    assign bus.timer_pause     = timer_pause_q;
    assign bus.countdown_on    = cd_on_q;
    assign bus.countdown_digit = digit_q;
    assign bus.lap_count       = lap_q;
    assign bus.race_done       = race_done_q;
    assign bus.timed_out       = timed_out_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Directed bench for race_sequencer with STEP_FRAMES=2, PEN_FRAMES=3, NUM_LAPS=3.
// Expected best_lap follows BEST_LAP_EN.
module tb_race_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    race_sequencer_if bus ();

    race_sequencer #(
        .NUM_LAPS   (3),
        .STEP_FRAMES(2),
        .PEN_FRAMES (3),
        .MAX_TIME   (999)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

`ifdef BEST_LAP_EN
    localparam logic [9:0] EXP_BEST_1 = 10'd50;
    localparam logic [9:0] EXP_BEST_3 = 10'd40;
`else
    localparam logic [9:0] EXP_BEST_1 = 10'h3FF;
    localparam logic [9:0] EXP_BEST_3 = 10'h3FF;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            bus.refresh_tick = 1'b1;
            cyc(1);
            bus.refresh_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic lap_at(input logic [9:0] t);
        bus.race_time = t;
        bus.lap_cross = 1'b1;
        cyc(1);
        bus.lap_cross = 1'b0;
    endtask

    task automatic press_start;
        bus.start_btn = 1'b1;
        cyc(1);
        bus.start_btn = 1'b0;
    endtask

    initial begin
        bus.refresh_tick = 1'b0;
        bus.start_btn    = 1'b0;
        bus.pause_btn    = 1'b0;
        bus.crash        = 1'b0;
        bus.lap_cross    = 1'b0;
        bus.race_time    = '0;
        cyc(3);

        // Reset state
        check_eq("rst_state", bus.state, 0);
        check_eq("rst_timer_reset", bus.timer_reset, 1);
        check_eq("rst_timer_pause", bus.timer_pause, 1);
        check_eq("rst_countdown_on", bus.countdown_on, 0);
        check_eq("rst_digit", bus.countdown_digit, 3);
        check_eq("rst_lap", bus.lap_count, 0);
        check_eq("rst_best", bus.best_lap, 10'h3FF);
        check_eq("rst_done", bus.race_done, 0);
        check_eq("rst_timed_out", bus.timed_out, 0);
        reset = 1'b0;
        cyc(1);

        // Countdown 3,2,1,GO
        press_start();
        check_eq("cd_state", bus.state, 1);
        check_eq("cd_on", bus.countdown_on, 1);
        check_eq("cd_digit3", bus.countdown_digit, 3);
        ticks(1);
        check_eq("cd_digit3_hold", bus.countdown_digit, 3);
        ticks(1);
        check_eq("cd_digit2", bus.countdown_digit, 2);
        ticks(2);
        check_eq("cd_digit1", bus.countdown_digit, 1);
        ticks(1);
        check_eq("cd_state_5ticks", bus.state, 1);
        ticks(1);
        check_eq("cd_digit_go", bus.countdown_digit, 0);
        check_eq("race_state", bus.state, 2);
        check_eq("race_timer_reset", bus.timer_reset, 0);
        check_eq("race_timer_pause", bus.timer_pause, 0);
        check_eq("go_on", bus.countdown_on, 1);
        ticks(1);
        check_eq("go_on_hold", bus.countdown_on, 1);
        ticks(1);
        check_eq("go_off", bus.countdown_on, 0);

        // Start edge while racing is ignored
        press_start();
        check_eq("start_ignored", bus.state, 2);

        // Pause toggle; lap ignored while paused
        bus.race_time = 10'd10;
        bus.pause_btn = 1'b1;
        cyc(1);
        check_eq("pause_timer_pause", bus.timer_pause, 1);
        check_eq("pause_state", bus.state, 3);
        lap_at(10'd12);
        check_eq("pause_lap_ignored", bus.lap_count, 0);
        bus.pause_btn = 1'b0;
        cyc(1);
        bus.pause_btn = 1'b1;
        cyc(1);
        check_eq("resume_timer_pause", bus.timer_pause, 0);
        check_eq("resume_state", bus.state, 2);
        bus.pause_btn = 1'b0;

        // Laps 1 and 2
        lap_at(10'd50);
        check_eq("lap1_count", bus.lap_count, 1);
        check_eq("lap1_best", bus.best_lap, EXP_BEST_1);
        lap_at(10'd120);
        check_eq("lap2_count", bus.lap_count, 2);
        check_eq("lap2_best", bus.best_lap, EXP_BEST_1);

        // Crash penalty, crash held high does not re-enter
        bus.crash = 1'b1;
        cyc(1);
        check_eq("pen_state", bus.state, 4);
        check_eq("pen_timer_pause", bus.timer_pause, 0);
        ticks(2);
        check_eq("pen_state_2ticks", bus.state, 4);
        ticks(1);
        check_eq("pen_exit", bus.state, 2);
        cyc(4);
        check_eq("crash_held", bus.state, 2);
        bus.crash = 1'b0;
        cyc(1);

        // Final lap
        lap_at(10'd160);
        check_eq("lap3_count", bus.lap_count, 3);
        check_eq("lap3_best", bus.best_lap, EXP_BEST_3);
        check_eq("fin_state", bus.state, 5);
        check_eq("fin_done", bus.race_done, 1);
        check_eq("fin_timer_pause", bus.timer_pause, 1);
        check_eq("fin_timed_out", bus.timed_out, 0);

        // Restart from FINISHED clears stats
        bus.race_time = '0;
        press_start();
        check_eq("restart_state", bus.state, 1);
        check_eq("restart_lap", bus.lap_count, 0);
        check_eq("restart_best", bus.best_lap, 10'h3FF);
        check_eq("restart_digit", bus.countdown_digit, 3);
        check_eq("restart_done", bus.race_done, 0);
        ticks(6);
        check_eq("restart_racing", bus.state, 2);

        // Timeout beats a simultaneous lap_cross
        lap_at(10'd999);
        check_eq("to_state", bus.state, 5);
        check_eq("to_timed_out", bus.timed_out, 1);
        check_eq("to_lap", bus.lap_count, 0);
        bus.race_time = '0;

        // Async reset mid-countdown
        press_start();
        check_eq("r6_timed_out_clr", bus.timed_out, 0);
        ticks(2);
        check_eq("r6_digit2", bus.countdown_digit, 2);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_state", bus.state, 0);
        check_eq("async_digit", bus.countdown_digit, 3);
        check_eq("async_on", bus.countdown_on, 0);
        check_eq("async_timer_reset", bus.timer_reset, 1);
        check_eq("async_timer_pause", bus.timer_pause, 1);
        cyc(2);
        reset = 1'b0;
        cyc(1);
        press_start();
        check_eq("r6_restart_state", bus.state, 1);
        check_eq("r6_restart_digit", bus.countdown_digit, 3);
        ticks(2);
        check_eq("r6_restart_digit2", bus.countdown_digit, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
